boot_cmd_sequencer: RTL and testbench
=====================================

// Module: boot_cmd_sequencer
// PURPOSE
//  Command sequencer behind the 6-byte SPI slave frame decoder in the bootloader.
//  Decodes byte0 = opcode and byte1 = address, then runs a single-request memory handshake.
//  Commands: 0x01 WRITE, 0x02 READ, 0x03 STATUS, 0x04 BOOT.
//  Drives the 32-bit reply word that the SPI slave shifts out in bytes 2..5.
// PARAMETERS
//  ADDR_W       8     memory address width; MEM_ADDR = {{ADDR_W-8{1'b0}}, RX1}
//  ACK_TIMEOUT  255   max CLK cycles a request is held waiting for MEM_ACK
// PORTS
//  CLK        in   1   system clock; all logic on posedge
//  RST_N      in   1   asynchronous, active-low reset
//  CS         in   1   SPI chip select, active-low; high = no frame
//  RX0..RX5   in   8   frame bytes from the SPI slave (OUT0..OUT5)
//  RXSTROBE   in   6   one-cycle strobe per byte; bit n => RXn is valid
//  REPLY      out  32  reply word, to the SPI slave IN port
//  MEM_ADDR   out  ADDR_W  memory address
//  MEM_WDATA  out  32  write data
//  MEM_WE     out  1   write request; held high until MEM_ACK or timeout
//  MEM_RE     out  1   read request; held high until MEM_ACK or timeout
//  MEM_RDATA  in   32  read data; valid in the MEM_ACK cycle
//  MEM_ACK    in   1   one-cycle completion of the current request
//  BOOT_GO    out  1   level output; releases the target CPU
//  BUSY       out  1   high in any state other than IDLE or WAIT_END
// BEHAVIOUR
//  Reset values: REPLY=0, MEM_ADDR=0, MEM_WDATA=0, MEM_WE=0, MEM_RE=0, BOOT_GO=0, BUSY=0.
//  Reset also clears all flags and WRCNT, and puts the FSM in IDLE.
//  FSM states: IDLE, GOT_OP, RD_REQ, WAIT_DATA, WR_REQ, WAIT_END.
//  IDLE: on RXSTROBE[0], latch opcode -> GOT_OP.
//  GOT_OP: on RXSTROBE[1], latch address, then branch on opcode:
//   READ   -> RD_REQ; MEM_RE=1 on the next cycle.
//   WRITE  -> WAIT_DATA.
//   STATUS -> REPLY=STATUS word, next cycle -> WAIT_END.
//   BOOT   -> BOOT_GO=1 (sticky until reset), REPLY=STATUS -> WAIT_END.
//   other  -> set BADOP, REPLY=STATUS -> WAIT_END.
//  RD_REQ: on MEM_ACK, REPLY<=MEM_RDATA and MEM_RE=0 -> WAIT_END.
//   If the ACK comes after RXSTROBE[2], also set LATE (the reply was already partly shifted).
//  WAIT_DATA: on RXSTROBE[5], MEM_WDATA<={RX2,RX3,RX4,RX5} and MEM_WE=1 -> WR_REQ.
//  WR_REQ: on MEM_ACK, MEM_WE=0 and WRCNT+=1 (16-bit, wraps 0xFFFF->0) -> IDLE.
//  WAIT_END: -> IDLE when CS=1.
//  Timeout: the counter runs from the cycle the request is asserted.
//   At count==ACK_TIMEOUT with no ACK: drop the request, set TOUT, -> WAIT_END.
//   A READ that times out returns REPLY=0xDEADDEAD.
//  Abort: CS=1 in GOT_OP or WAIT_DATA -> IDLE, with no memory access.
//   CS=1 in RD_REQ or WR_REQ does not abort; the request still completes or times out.
//  Overrun: RXSTROBE[0] while in RD_REQ or WR_REQ sets OVR.
//   The new frame is ignored; the FSM returns to WAIT_END, not IDLE, after the request.
//  Simultaneous MEM_ACK and timeout in one cycle: the ACK wins.
//  STATUS word = {8'hB0, 3'b0, VERR, LATE, BADOP, TOUT, OVR, WRCNT[15:0]}.
//  Flags are sticky. They clear on the CS rising edge that ends a STATUS frame.
//   A flag set in that same cycle stays set.
//  RXSTROBE bits are ignored in any state that does not expect them.
// CONFIGURATION
//  WRITE_VERIFY_EN defined:
//   After the WRITE ACK, add state WR_VFY: MEM_RE=1 at the same address.
//   On the read ACK, compare MEM_RDATA to MEM_WDATA; a mismatch sets VERR.
//   WRCNT increments only when the data matches. A timeout in WR_VFY sets TOUT.
//  WRITE_VERIFY_EN undefined:
//   No WR_VFY state; VERR is tied to 0; WRCNT increments on every write ACK.
// TESTING
//  1) WRITE 01,10,DE,AD,BE,EF, ACK 3 cycles after MEM_WE
//     -> MEM_ADDR=0x10, MEM_WDATA=0xDEADBEEF, one ACK, WRCNT=1.
//  2) MEM holds 0x12345678 at 0x20; READ 02,20, ACK 2 cycles after MEM_RE
//     -> REPLY=0x12345678 before RXSTROBE[2]; LATE=0.
//  3) READ with MEM_ACK never asserted
//     -> MEM_RE drops after 255 cycles; REPLY=0xDEADDEAD; STATUS bit TOUT=1.
//  4) WRITE frame where CS rises after byte 3 -> no MEM_WE, FSM back in IDLE, WRCNT unchanged.
//  5) Opcode 0x7F then STATUS -> STATUS shows BADOP=1; a second STATUS shows BADOP=0.
//  6) RST_N low during WR_REQ -> MEM_WE=0 immediately; later BOOT -> BOOT_GO=1 and held.
//     With WRITE_VERIFY_EN, a corrupted readback -> VERR=1 and WRCNT unchanged.

Source files
------------

// File: rtl/boot_cmd_sequencer_if.sv
// Memory-side handshake bundle for boot_cmd_sequencer.
// The master (the sequencer) holds a single WE or RE request until the slave
// answers with a one-cycle MEM_ACK; read data is valid in the ACK cycle.
interface boot_cmd_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] MEM_ADDR;
   logic [31:0]       MEM_WDATA;
   logic              MEM_WE;
   logic              MEM_RE;
   logic [31:0]       MEM_RDATA;
   logic              MEM_ACK;

   modport master (
      output MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE,
      input  MEM_RDATA, MEM_ACK
   );

   modport slave (
      input  MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE,
      output MEM_RDATA, MEM_ACK
   );
endinterface

// File: rtl/boot_cmd_sequencer.sv
// Bootloader command sequencer behind the 6-byte SPI frame decoder.
// byte0 = opcode, byte1 = address; WRITE takes bytes 2..5 as data, READ/STATUS/BOOT
// return a 32-bit reply word that the SPI slave shifts out as bytes 2..5.
// Optional build macro WRITE_VERIFY_EN: every write is read back and compared;
// a mismatch raises VERR and the write is not counted in WRCNT.
module boot_cmd_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 CS,
   input  logic [7:0]           RX0,
   input  logic [7:0]           RX1,
   input  logic [7:0]           RX2,
   input  logic [7:0]           RX3,
   input  logic [7:0]           RX4,
   input  logic [7:0]           RX5,
   input  logic [5:0]           RXSTROBE,
   output logic [31:0]          REPLY,
   output logic                 BOOT_GO,
   output logic                 BUSY,
   boot_cmd_sequencer_if.master mem
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [7:0] OP_WRITE  = 8'h01;
   localparam logic [7:0] OP_READ   = 8'h02;
   localparam logic [7:0] OP_STATUS = 8'h03;
   localparam logic [7:0] OP_BOOT   = 8'h04;

   typedef enum logic [2:0] {
      IDLE, GOT_OP, RD_REQ, WAIT_DATA, WR_REQ, WAIT_END
`ifdef WRITE_VERIFY_EN
      , WR_VFY
`endif
   } state_t;

   state_t          state;
   logic [7:0]      opcode;
   logic [TW-1:0]   tcnt;          // cycles the current request has been held
   logic [15:0]     wrcnt;
   logic            tout, ovr, badop, late;
   logic            verr;
   logic            status_frame;  // current frame is a STATUS read: clears flags at its end
   logic            ovr_pend;      // a new frame arrived during the request
   logic            rx2_seen;      // byte 2 already taken while the read was pending
   logic            cs_q;
   logic            cs_rise, in_req, ovr_now, tmo;

   assign cs_rise = CS & ~cs_q;
`ifdef WRITE_VERIFY_EN
   assign in_req  = (state == RD_REQ) || (state == WR_REQ) || (state == WR_VFY);
`else
   assign in_req  = (state == RD_REQ) || (state == WR_REQ);
   assign verr    = 1'b0;
`endif
   assign ovr_now = RXSTROBE[0] & in_req;
   assign tmo     = (tcnt == TW'(ACK_TIMEOUT));
   assign BUSY    = (state != IDLE) && (state != WAIT_END);

   function automatic logic [31:0] status_word(input logic badop_v);
      return {8'hB0, 3'b000, verr, late, badop_v, tout, ovr, wrcnt};
   endfunction

   // Command FSM, memory handshake, sticky flags and reply register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         opcode        <= '0;
         tcnt          <= '0;
         wrcnt         <= '0;
         tout          <= 1'b0;
         ovr           <= 1'b0;
         badop         <= 1'b0;
         late          <= 1'b0;
`ifdef WRITE_VERIFY_EN
         verr          <= 1'b0;
`endif
         status_frame  <= 1'b0;
         ovr_pend      <= 1'b0;
         rx2_seen      <= 1'b0;
         cs_q          <= 1'b1;
         REPLY         <= '0;
         BOOT_GO       <= 1'b0;
         mem.MEM_ADDR  <= '0;
         mem.MEM_WDATA <= '0;
         mem.MEM_WE    <= 1'b0;
         mem.MEM_RE    <= 1'b0;
      end else begin
         cs_q <= CS;
         // Clear comes first so any flag set further down in this cycle survives
         if (cs_rise) begin
            status_frame <= 1'b0;
            if (status_frame) begin
               tout  <= 1'b0;
               ovr   <= 1'b0;
               badop <= 1'b0;
               late  <= 1'b0;
`ifdef WRITE_VERIFY_EN
               verr  <= 1'b0;
`endif
            end
         end
         if (ovr_now) begin
            ovr      <= 1'b1;
            ovr_pend <= 1'b1;
         end
         case (state)
            IDLE: if (RXSTROBE[0]) begin
               opcode <= RX0;
               state  <= GOT_OP;
            end
            GOT_OP: if (CS) state <= IDLE;
            else if (RXSTROBE[1]) begin
               mem.MEM_ADDR <= ADDR_W'(RX1);
               ovr_pend     <= 1'b0;
               rx2_seen     <= 1'b0;
               tcnt         <= TW'(1);
               case (opcode)
                  OP_READ:  begin mem.MEM_RE <= 1'b1; state <= RD_REQ; end
                  OP_WRITE: state <= WAIT_DATA;
                  OP_STATUS: begin
                     REPLY        <= status_word(badop);
                     status_frame <= 1'b1;
                     state        <= WAIT_END;
                  end
                  OP_BOOT: begin
                     BOOT_GO <= 1'b1;
                     REPLY   <= status_word(badop);
                     state   <= WAIT_END;
                  end
                  default: begin
                     badop <= 1'b1;
                     REPLY <= status_word(1'b1);
                     state <= WAIT_END;
                  end
               endcase
            end
            RD_REQ: begin
               if (RXSTROBE[2]) rx2_seen <= 1'b1;
               if (mem.MEM_ACK) begin
                  REPLY      <= mem.MEM_RDATA;
                  mem.MEM_RE <= 1'b0;
                  // REPLY lands a cycle after the ACK, so a byte-2 strobe in the
                  // ACK cycle has already missed it too
                  if (rx2_seen || RXSTROBE[2]) late <= 1'b1;
                  state      <= WAIT_END;
               end else if (tmo) begin
                  REPLY      <= 32'hDEAD_DEAD;
                  mem.MEM_RE <= 1'b0;
                  tout       <= 1'b1;
                  state      <= WAIT_END;
               end else tcnt <= tcnt + TW'(1);
            end
            WAIT_DATA: if (CS) state <= IDLE;
            else if (RXSTROBE[5]) begin
               mem.MEM_WDATA <= {RX2, RX3, RX4, RX5};
               mem.MEM_WE    <= 1'b1;
               tcnt          <= TW'(1);
               state         <= WR_REQ;
            end
            WR_REQ: begin
               if (mem.MEM_ACK) begin
                  mem.MEM_WE <= 1'b0;
`ifdef WRITE_VERIFY_EN
                  mem.MEM_RE <= 1'b1;
                  tcnt       <= TW'(1);
                  state      <= WR_VFY;
`else
                  wrcnt      <= wrcnt + 16'd1;
                  state      <= (ovr_pend || ovr_now) ? WAIT_END : IDLE;
`endif
               end else if (tmo) begin
                  mem.MEM_WE <= 1'b0;
                  tout       <= 1'b1;
                  state      <= WAIT_END;
               end else tcnt <= tcnt + TW'(1);
            end
`ifdef WRITE_VERIFY_EN
            WR_VFY: begin
               if (mem.MEM_ACK) begin
                  mem.MEM_RE <= 1'b0;
                  if (mem.MEM_RDATA == mem.MEM_WDATA) wrcnt <= wrcnt + 16'd1;
                  else verr <= 1'b1;
                  state      <= (ovr_pend || ovr_now) ? WAIT_END : IDLE;
               end else if (tmo) begin
                  mem.MEM_RE <= 1'b0;
                  tout       <= 1'b1;
                  state      <= WAIT_END;
               end else tcnt <= tcnt + TW'(1);
            end
`endif
            WAIT_END: if (CS) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_boot_cmd_sequencer.sv
// Self-checking bench for boot_cmd_sequencer: table of command frames plus
// hand-written corner sequences; memory accesses checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_boot_cmd_sequencer;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        CS = 1'b1;
   logic [7:0]  rx [6];
   logic [5:0]  strobe;
   logic [31:0] REPLY;
   logic        BOOT_GO, BUSY;

   boot_cmd_sequencer_if #(.ADDR_W(8)) mif ();

   boot_cmd_sequencer #(.ADDR_W(8), .ACK_TIMEOUT(255)) dut (
      .CLK(CLK), .RST_N(RST_N), .CS(CS),
      .RX0(rx[0]), .RX1(rx[1]), .RX2(rx[2]), .RX3(rx[3]), .RX4(rx[4]), .RX5(rx[5]),
      .RXSTROBE(strobe), .REPLY(REPLY), .BOOT_GO(BOOT_GO), .BUSY(BUSY), .mem(mif)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
   } acc_t;

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  addr;
      logic [31:0] data;
      int          dly;
      logic [31:0] exp_reply;
      logic        chk_reply;
   } vec_t;

   acc_t        exp_q[$];
   int          n_cmp = 0, n_bad = 0;
   int          ack_dly = 2, ack_cnt = 0, re_cycles = 0;
   bit          ack_en = 1'b1, corrupt = 1'b0, we_seen = 1'b0;
   logic [31:0] mem [256];
   logic [31:0] rep_s2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: ACK arrives in the ack_dly-th cycle a request is seen high
   initial begin
      int   c;
      acc_t e;
      c = 0;
      mif.MEM_ACK   = 1'b0;
      mif.MEM_RDATA = '0;
      forever begin
         @(posedge CLK); #1;
         if (mif.MEM_ACK) begin
            mif.MEM_ACK = 1'b0;
            c = 0;
         end else if (RST_N && ack_en && (mif.MEM_WE || mif.MEM_RE)) begin
            c++;
            if (c >= ack_dly) begin
               mif.MEM_ACK = 1'b1;
               ack_cnt++;
               chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("sb_kind", {31'b0, mif.MEM_WE}, {31'b0, e.we});
                  chk("sb_addr", {24'b0, mif.MEM_ADDR}, {24'b0, e.addr});
                  if (e.we) chk("sb_wdata", mif.MEM_WDATA, e.data);
               end
               if (mif.MEM_WE) mem[mif.MEM_ADDR] = mif.MEM_WDATA;
               else mif.MEM_RDATA = mem[mif.MEM_ADDR] ^ (corrupt ? 32'h0000_0100 : 32'h0);
            end
         end else c = 0;
      end
   end

   // Request monitor
   initial forever begin
      @(negedge CLK);
      if (mif.MEM_RE) re_cycles++;
      if (mif.MEM_WE) we_seen = 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // One SPI frame: nb bytes, gap idle cycles after each, then CS high; REPLY captured at byte 2
   task automatic send(input logic [47:0] f, input int nb, input int gap);
      CS = 1'b0;
      repeat (2) @(posedge CLK); #1;
      for (int i = 0; i < nb; i++) begin
         rx[i]  = f[47-8*i -: 8];
         strobe = 6'(1 << i);
         if (i == 2) rep_s2 = REPLY;
         @(posedge CLK); #1;
         strobe = '0;
         repeat (gap) @(posedge CLK); #1;
      end
      CS = 1'b1;
      repeat (3) @(posedge CLK); #1;
   endtask

   task automatic status(input string nm, input logic [31:0] exp);
      send({8'h03, 40'h0}, 6, 4);
      chk(nm, rep_s2, exp);
   endtask

   vec_t vt [5];

   initial begin
      int exp_acks;
      vt[0] = '{8'h01, 8'h10, 32'hDEADBEEF, 3, 32'h0,         1'b0};
      vt[1] = '{8'h02, 8'h20, 32'h0,        2, 32'h12345678,  1'b1};
      vt[2] = '{8'h01, 8'h30, 32'hA5A55A5A, 1, 32'h0,         1'b0};
      vt[3] = '{8'h02, 8'h30, 32'h0,        5, 32'hA5A55A5A,  1'b1};
      vt[4] = '{8'h03, 8'h00, 32'h0,        2, 32'hB0000002,  1'b1};
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h20] = 32'h12345678;
      for (int i = 0; i < 6; i++) rx[i] = '0;
      strobe = '0;

      // Reset state
      repeat (3) @(posedge CLK); #1;
      chk("rst_reply", REPLY, 32'h0);
      chk("rst_addr",  {24'b0, mif.MEM_ADDR}, 32'h0);
      chk("rst_wdata", mif.MEM_WDATA, 32'h0);
      chk("rst_we",    {31'b0, mif.MEM_WE}, 32'h0);
      chk("rst_re",    {31'b0, mif.MEM_RE}, 32'h0);
      chk("rst_boot",  {31'b0, BOOT_GO}, 32'h0);
      chk("rst_busy",  {31'b0, BUSY}, 32'h0);
      RST_N = 1'b1;
      repeat (2) @(posedge CLK); #1;

      // Table: writes, reads and a status readback
      for (int i = 0; i < 5; i++) begin
         ack_dly  = vt[i].dly;
         ack_cnt  = 0;
         exp_acks = 0;
         if (vt[i].op == 8'h01) begin
            exp_q.push_back('{1'b1, vt[i].addr, vt[i].data});
            exp_acks = 1;
`ifdef WRITE_VERIFY_EN
            exp_q.push_back('{1'b0, vt[i].addr, vt[i].data});
            exp_acks = 2;
`endif
         end else if (vt[i].op == 8'h02) begin
            exp_q.push_back('{1'b0, vt[i].addr, 32'h0});
            exp_acks = 1;
         end
         send({vt[i].op, vt[i].addr, vt[i].data}, 6, 8);
         if (vt[i].chk_reply) chk($sformatf("v%0d_reply", i), rep_s2, vt[i].exp_reply);
         if (vt[i].op == 8'h01 || vt[i].op == 8'h02)
            chk($sformatf("v%0d_addr", i), {24'b0, mif.MEM_ADDR}, {24'b0, vt[i].addr});
         if (vt[i].op == 8'h01) chk($sformatf("v%0d_wdata", i), mif.MEM_WDATA, vt[i].data);
         chk($sformatf("v%0d_acks", i), ack_cnt, exp_acks);
         chk($sformatf("v%0d_idle", i), {31'b0, BUSY}, 32'h0);
      end

      // Read ACK arriving after byte 2 -> LATE
      ack_dly = 20;
      exp_q.push_back('{1'b0, 8'h20, 32'h0});
      send({8'h02, 8'h20, 32'h0}, 6, 8);
      status("late_status", 32'hB0080002);

      // Read never acknowledged -> 255-cycle request, DEADDEAD, TOUT
      ack_en = 1'b0;
      re_cycles = 0;
      send({8'h02, 8'h40, 32'h0}, 6, 300);
      chk("tout_re_cycles", re_cycles, 255);
      chk("tout_reply", rep_s2, 32'hDEADDEAD);
      ack_en = 1'b1;
      status("tout_status", 32'hB0020002);

      // WRITE aborted by CS after byte 3 -> no access, back in IDLE
      we_seen = 1'b0;
      ack_cnt = 0;
      send({8'h01, 8'h60, 32'h01020304}, 4, 2);
      chk("abort_we", {31'b0, we_seen}, 32'h0);
      chk("abort_idle", {31'b0, BUSY}, 32'h0);
      status("abort_status", 32'hB0000002);

      // Bad opcode, then two STATUS frames: first sees BADOP, second cleared
      send({8'h7F, 8'h00, 32'h0}, 6, 4);
      status("badop_status1", 32'hB0040002);
      status("badop_status2", 32'hB0000002);

      // Reset while the write request is pending
      ack_en = 1'b0;
      send({8'h01, 8'h70, 32'h55AA55AA}, 6, 2);
      chk("wr_pending_we", {31'b0, mif.MEM_WE}, 32'h1);
      RST_N = 1'b0;
      #1;
      chk("rst_async_we", {31'b0, mif.MEM_WE}, 32'h0);
      chk("rst_async_busy", {31'b0, BUSY}, 32'h0);
      repeat (2) @(posedge CLK); #1;
      RST_N = 1'b1;
      ack_en = 1'b1;
      repeat (2) @(posedge CLK); #1;
      status("post_rst_status", 32'hB0000000);

      // BOOT releases the CPU and stays released
      send({8'h04, 8'h00, 32'h0}, 6, 4);
      chk("boot_go", {31'b0, BOOT_GO}, 32'h1);
      repeat (20) @(posedge CLK); #1;
      chk("boot_go_hold", {31'b0, BOOT_GO}, 32'h1);
      status("boot_status", 32'hB0000000);
      chk("boot_go_after_status", {31'b0, BOOT_GO}, 32'h1);

`ifdef WRITE_VERIFY_EN
      // Corrupted readback -> VERR, write not counted
      corrupt = 1'b1;
      ack_dly = 2;
      ack_cnt = 0;
      exp_q.push_back('{1'b1, 8'h50, 32'h11223344});
      exp_q.push_back('{1'b0, 8'h50, 32'h11223344});
      send({8'h01, 8'h50, 32'h11223344}, 6, 8);
      chk("vfy_acks", ack_cnt, 2);
      corrupt = 1'b0;
      status("vfy_status", 32'hB0100000);
`endif

      chk("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
